// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between the input buffers of one router output port and its arbiter.
// The arbiter takes the slave view; the requesting side (buffers or a bench) takes the master view.
interface noc_rr_arbiter_if #(
  parameter int N     = 5,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic [N-1:0]     tail;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  modport master (
    output req,
    output tail,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx
  );

  modport slave (
    input  req,
    input  tail,
    output gnt,
    output gnt_valid,
    output gnt_idx
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Output-port arbiter: round-robin or fixed-priority, lock until tail/drop/timeout,
// re-arbitration on release with the outgoing holder excluded, all outputs registered.
module noc_rr_arbiter #(
  parameter int N        = 5,
  parameter int MODE_RR  = 1,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 3
) (
  input logic             clk,
  input logic             rst,
  noc_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_WIDE    = (IDX_W + 1)'(N);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gv_q, gv_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [N-1:0]     cand;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   sum;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] ptr_nxt;

  logic holder_req;
  logic holder_tail;
  logic timeout;
  logic rel;
  logic grant_new;

  // gnt_q is zero in IDLE, so this mask is "everyone" there and "everyone but the holder" in GRANT.
  assign cand = bus.req & ~gnt_q;

  assign holder_req  = |(bus.req & gnt_q);
  assign holder_tail = |(bus.req & bus.tail & gnt_q);
  assign timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign rel         = !holder_req || holder_tail || timeout;

  // Winner search: rotate candidates so the priority start sits at bit 0, take the lowest set
  // bit, then rotate the offset back into an absolute index.
  always_comb begin
    base = (MODE_RR != 0) ? ptr_q : '0;
    dbl  = {cand, cand};
    rot  = N'(dbl >> base);
    off  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    win_found = |rot;
    sum       = {1'b0, off} + {1'b0, base};
    if (sum >= N_WIDE) sum = sum - N_WIDE;
    win_idx = sum[IDX_W-1:0];
    ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
  end

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gv_d      = gv_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_new = 1'b0;

    case (state_q)
      IDLE: begin
        grant_new = win_found;
      end
      GRANT: begin
        if (rel) begin
          if (win_found) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            gv_d    = 1'b0;
            idx_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = N'(1) << win_idx;
      gv_d    = 1'b1;
      idx_d   = win_idx;
      hold_d  = '0;
      ptr_d   = ptr_nxt;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gv_q;
  assign bus.gnt_idx   = idx_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_valid   : assert property (@(posedge clk) disable iff (rst) gv_q == (|gnt_q));
  a_gnt_idx     : assert property (@(posedge clk) disable iff (rst)
                    gv_q ? (gnt_q == (N'(1) << idx_q)) : (idx_q == '0));

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter: five parameter variants share one stimulus stream; each is checked
// every cycle against an integer-level model, with directed literal expectations on top.
module tb_noc_rr_arbiter;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [4:0] req  = 5'b11111;
  logic [4:0] tail = 5'b00000;
  bit         armed = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter_if #(.N(5), .IDX_W(3)) if_rr ();
  noc_rr_arbiter_if #(.N(5), .IDX_W(3)) if_fp ();
  noc_rr_arbiter_if #(.N(5), .IDX_W(3)) if_to ();
  noc_rr_arbiter_if #(.N(5), .IDX_W(3)) if_m1 ();
  noc_rr_arbiter_if #(.N(2), .IDX_W(1)) if_n2 ();

  assign if_rr.req = req;       assign if_rr.tail = tail;
  assign if_fp.req = req;       assign if_fp.tail = tail;
  assign if_to.req = req;       assign if_to.tail = tail;
  assign if_m1.req = req;       assign if_m1.tail = tail;
  assign if_n2.req = req[1:0];  assign if_n2.tail = tail[1:0];

  noc_rr_arbiter #(.N(5), .MODE_RR(1), .MAX_HOLD(0), .CNT_W(8), .IDX_W(3))
    u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  noc_rr_arbiter #(.N(5), .MODE_RR(0), .MAX_HOLD(0), .CNT_W(8), .IDX_W(3))
    u_fp (.clk(clk), .rst(rst), .bus(if_fp));
  noc_rr_arbiter #(.N(5), .MODE_RR(1), .MAX_HOLD(4), .CNT_W(8), .IDX_W(3))
    u_to (.clk(clk), .rst(rst), .bus(if_to));
  noc_rr_arbiter #(.N(5), .MODE_RR(1), .MAX_HOLD(1), .CNT_W(8), .IDX_W(3))
    u_m1 (.clk(clk), .rst(rst), .bus(if_m1));
  noc_rr_arbiter #(.N(2), .MODE_RR(1), .MAX_HOLD(0), .CNT_W(8), .IDX_W(1))
    u_n2 (.clk(clk), .rst(rst), .bus(if_n2));

  // holder = -1 means nobody holds the port.
  typedef struct packed {
    int holder;
    int ptr;
    int cnt;
  } mstate_t;

  mstate_t m_rr = '{holder: -1, ptr: 0, cnt: 0};
  mstate_t m_fp = '{holder: -1, ptr: 0, cnt: 0};
  mstate_t m_to = '{holder: -1, ptr: 0, cnt: 0};
  mstate_t m_m1 = '{holder: -1, ptr: 0, cnt: 0};
  mstate_t m_n2 = '{holder: -1, ptr: 0, cnt: 0};

  function automatic int pick(int cand, int n, bit rr, int start);
    for (int j = 0; j < n; j++) begin
      int i;
      i = rr ? (start + j) % n : j;
      if (((cand >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t step(mstate_t s, bit r, int rq, int tl, int n, bit rr, int mh);
    mstate_t t;
    int      k;
    int      h;
    bit      done;
    t = s;
    if (r) begin
      t.holder = -1; t.ptr = 0; t.cnt = 0;
    end else if (s.holder < 0) begin
      if (rq != 0) begin
        k = pick(rq, n, rr, s.ptr);
        t.holder = k; t.cnt = 0; t.ptr = (k + 1) % n;
      end
    end else begin
      h    = s.holder;
      done = (((rq >> h) & 1) == 0) || (((tl >> h) & 1) == 1) || (mh != 0 && s.cnt == mh - 1);
      if (!done) begin
        t.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
      end else begin
        k = pick(rq & ~(1 << h), n, rr, s.ptr);
        if (k >= 0) begin
          t.holder = k; t.cnt = 0; t.ptr = (k + 1) % n;
        end else begin
          t.holder = -1; t.cnt = 0;
        end
      end
    end
    return t;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string nm, mstate_t s, logic [15:0] g, logic v, logic [3:0] idx);
    logic [15:0] eg;
    logic [15:0] ei;
    eg = (s.holder >= 0) ? (16'(1) << s.holder) : 16'h0;
    ei = (s.holder >= 0) ? 16'(s.holder) : 16'h0;
    check({nm, "_gnt"}, g, eg);
    check({nm, "_valid"}, 16'(v), 16'(s.holder >= 0));
    check({nm, "_idx"}, 16'(idx), ei);
  endtask

  always @(posedge clk) begin
    m_rr = step(m_rr, rst, int'(req), int'(tail), 5, 1'b1, 0);
    m_fp = step(m_fp, rst, int'(req), int'(tail), 5, 1'b0, 0);
    m_to = step(m_to, rst, int'(req), int'(tail), 5, 1'b1, 4);
    m_m1 = step(m_m1, rst, int'(req), int'(tail), 5, 1'b1, 1);
    m_n2 = step(m_n2, rst, int'(req[1:0]), int'(tail[1:0]), 2, 1'b1, 0);
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp("m_rr", m_rr, 16'(if_rr.gnt), if_rr.gnt_valid, 4'(if_rr.gnt_idx));
      cmp("m_fp", m_fp, 16'(if_fp.gnt), if_fp.gnt_valid, 4'(if_fp.gnt_idx));
      cmp("m_to", m_to, 16'(if_to.gnt), if_to.gnt_valid, 4'(if_to.gnt_idx));
      cmp("m_m1", m_m1, 16'(if_m1.gnt), if_m1.gnt_valid, 4'(if_m1.gnt_idx));
      cmp("m_n2", m_n2, 16'(if_n2.gnt), if_n2.gnt_valid, 4'(if_n2.gnt_idx));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; tail = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 2, 4, 0, 2};

    // Reset held two cycles with every input requesting.
    @(negedge clk);
    armed = 1'b1;
    check("t1_rst_gnt_c0", 16'(if_rr.gnt), 16'h0);
    check("t1_rst_valid_c0", 16'(if_rr.gnt_valid), 16'h0);
    check("t1_rst_idx_c0", 16'(if_rr.gnt_idx), 16'h0);
    @(negedge clk);
    check("t1_rst_gnt_c1", 16'(if_rr.gnt), 16'h0);
    check("t1_rst_idx_c1", 16'(if_rr.gnt_idx), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_gnt", 16'(if_rr.gnt), 16'h01);
    check("t1_first_valid", 16'(if_rr.gnt_valid), 16'h1);

    // Round-robin rotation over inputs 0, 2, 4 with a tail every cycle.
    do_reset();
    req = 5'b10101; tail = 5'b11111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t2_rr_idx", 16'(if_rr.gnt_idx), 16'(exp_rr[c]));
      check("t2_rr_valid", 16'(if_rr.gnt_valid), 16'h1);
    end

    // Fixed priority never re-grants the releasing holder; N=2 pointer toggles.
    do_reset();
    req = 5'b00011; tail = 5'b00011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_fp_idx", 16'(if_fp.gnt_idx), 16'(c % 2));
      check("t3_n2_idx", 16'(if_n2.gnt_idx), 16'(c % 2));
    end

    // Lock until drop; a late requester does not pre-empt.
    do_reset();
    req = 5'b01000; tail = 5'b00000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_lock_gnt", 16'(if_rr.gnt), 16'h08);
      if (c == 3) req = 5'b01010;
    end
    req = 5'b00010;
    @(negedge clk);
    check("t4_drop_gnt", 16'(if_rr.gnt), 16'h02);

    // Timeout after four cycles alternates between inputs 1 and 2.
    do_reset();
    req = 5'b00110; tail = 5'b00000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("t5_to_idx", 16'(if_to.gnt_idx), ((c / 4) % 2 == 0) ? 16'd1 : 16'd2);
    end

    // Reset mid-grant clears the pointer.
    do_reset();
    req = 5'b00100; tail = 5'b00000;
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("t6_hold_gnt", 16'(if_rr.gnt), 16'h04);
    rst = 1'b1; req = 5'b01110;
    @(negedge clk);
    check("t6_rst_gnt", 16'(if_rr.gnt), 16'h0);
    check("t6_rst_valid", 16'(if_rr.gnt_valid), 16'h0);
    check("t6_rst_idx", 16'(if_rr.gnt_idx), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_idx", 16'(if_rr.gnt_idx), 16'd1);

    // Lone requester releasing on tail gets a bubble between packets.
    do_reset();
    req = 5'b10000; tail = 5'b10000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_self_gnt", 16'(if_rr.gnt), (c % 2 == 0) ? 16'h10 : 16'h0);
    end

    // MAX_HOLD=1 gives one-cycle grants; the unlimited instance keeps holding.
    do_reset();
    req = 5'b00011; tail = 5'b00000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t7_m1_idx", 16'(if_m1.gnt_idx), 16'(c % 2));
      check("t7_m1_valid", 16'(if_m1.gnt_valid), 16'h1);
      check("t7_rr_idx", 16'(if_rr.gnt_idx), 16'h0);
    end

    do_reset();
    repeat (3) @(negedge clk);
    check("t8_idle_gnt", 16'(if_rr.gnt), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
Name: noc_rr_arbiter

Overview:
Parametrised output-port arbiter for the router crossbar. It is the successor to the fixed 5-input lock-until-drop arbiter. It adds:
- N inputs.
- Selectable round-robin or fixed-priority selection.
- Packet-tail release.
- An optional maximum-hold timeout.
- Back-to-back re-arbitration with no idle bubble.
One instance sits per router output port and drives the crossbar select and the input-buffer read enables.

Parameters:
N, 5, number of requesting inputs (2..16).
MODE_RR, 1, 1 = round-robin pointer priority; 0 = fixed priority, lowest index wins.
MAX_HOLD, 0, maximum consecutive grant cycles per holder; 0 = unlimited.
CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.
IDX_W, 3, width of gnt_idx; must satisfy 2^IDX_W >= N.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; one clock, synchronous, active-high
req  in  N  per-input request; bit i is level-held while input i wants the port
tail  in  N  per-input tail flag; qualified only when req[i]=1 and input i is the holder
gnt  out  N  registered one-hot grant, or all zero
gnt_valid  out  1  registered; high when gnt is non-zero
gnt_idx  out  IDX_W  registered binary index of the holder; 0 when gnt_valid=0

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, hold_cnt=0.
  - Reset mid-grant drops gnt to 0 at that edge. No tail or timeout is honoured.
- State machine: IDLE, GRANT. All outputs are registered. A grant appears the cycle after the request is sampled (1-cycle latency).
- Winner selection, sel(mask):
  - Candidates are req & mask.
  - MODE_RR=1: scan from index ptr upward, wrapping N-1 -> 0; first set bit wins.
  - MODE_RR=0: lowest set index wins; ptr is ignored.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant k=sel(all ones): state=GRANT, gnt=1<<k, gnt_idx=k, hold_cnt=0, ptr=(k+1) mod N.
- GRANT, holder h; a release event is evaluated every cycle:
  - (a) req[h]=0, or
  - (b) req[h]=1 and tail[h]=1 (the tail flit transfers this cycle), or
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - No release: keep gnt; hold_cnt increments, saturating at all-ones.
  - Release: re-arbitrate in the same cycle with mask = all ones except bit h.
    - If a winner k exists: gnt switches to k at the next edge with no bubble; hold_cnt=0; ptr=(k+1) mod N.
    - If no winner: go to IDLE; gnt=0 next cycle.
    - If h still requests, it competes again from IDLE on the following cycle.
- The holder is never re-granted directly on its own release, in either mode. This guarantees at least one bubble or a switch per packet.
- Priority among release causes: all three causes release identically. The count is irrelevant once any cause fires.
- tail[i] or req changes on non-holders have no effect while GRANT persists. No pre-emption except via timeout.
- MAX_HOLD=1: release every cycle. The holder alternates with any other requester, giving 1-cycle grants.
- ptr changes only on a new grant; it does not advance while idle.
- N=2 wrap: ptr toggles 0/1.
- Invariants:
  - gnt is one-hot or zero every cycle.
  - gnt_valid == |gnt.
  - gnt_idx is consistent with gnt.
  - No X on any output after the first reset edge.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles with req=5'b11111 -> gnt=0, gnt_valid=0, gnt_idx=0 throughout. Release rst -> gnt=5'b00001 one cycle later.
2. Round-robin fairness: MODE_RR=1, N=5, req=5'b10101 held, tail=1 on every grant cycle -> grants rotate 0,2,4,0,2 on consecutive cycles with no bubble.
3. Fixed priority with exclusion: MODE_RR=0, req=5'b00011 held, tail pulsed on each grant -> grant sequence 0,1,0,1. Input 0 never holds two consecutive packets while input 1 waits.
4. Lock and drop:
   - req[3]=1 alone for 10 cycles, tail=0 -> gnt=5'b01000 for 10 cycles.
   - Raise req[1] at cycle 4 -> no change.
   - Drop req[3] -> gnt=5'b00010 the next cycle.
5. Timeout: MAX_HOLD=4, req=5'b00110 held, tail=0 -> gnt[1] for exactly 4 cycles, then gnt[2] for 4 cycles, repeating. hold_cnt returns to 0 at each switch.
6. Reset mid-grant and lone-holder release:
   - Holder 2 with hold_cnt=3; assert rst one cycle -> gnt=0, ptr=0; first post-reset grant goes to the lowest set req index.
   - Separately, lone req[4] with tail=1 -> pattern gnt[4], 0, gnt[4] (bubble on self-release).
